uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
Byte-stream frame decoder between the UART receiver and the DTM register/DMI logic inside DTM_UART. Consumes received bytes over ready/valid and strips the ESC-based framing. Each completed frame is issued as one command (read, write or reset) with its 5-bit address and, for writes, the assembled LSB-first payload. Desynchronised, malformed or stalled frames are dropped and flagged.

Parameters:
ESC, 8'hB1, frame-start/escape byte value.
MAX_BYTES, 6, payload register width in bytes (covers the 41-bit DMI request).
TIMEOUT_CYCLES, 4096, idle clock cycles allowed between bytes of one frame before abort.

Ports:
CLK_I  in  1  clock
RST_NI  in  1  asynchronous active-low reset
RX_DATA_I  in  8  received byte
RX_VALID_I  in  1  received byte valid
RX_READY_O  out  1  decoder accepts byte
CMD_O  out  3  command: 3'b001 READ, 3'b010 WRITE, 3'b011 RESET
ADDR_O  out  5  target address: 5'h10 DTMCS, 5'h11 DMI, 5'h00-5'h03 STB registers
WDATA_O  out  8*MAX_BYTES  write payload, byte 0 in bits [7:0]
CMD_VALID_O  out  1  command valid
CMD_READY_I  in  1  consumer accepts command
ERR_O  out  1  one-cycle pulse on any dropped frame

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, payload register 0, timeout counter 0.
- A byte is accepted only when RX_VALID_I and RX_READY_O are both high on the same rising edge.
- RX_READY_O = 1 in every state except ISSUE.
- Command byte layout: {cmd[7:5], addr[4:0]}.
- Payload length by address: DTMCS = 4 bytes, DMI = 6 bytes, STB 0-3 = 4 bytes. Any other address is invalid.
- FSM states:
  - IDLE: non-ESC bytes are discarded silently. ESC -> HEADER.
  - HEADER: the next byte is the command byte.
    - ESC: stay in HEADER (repeated ESC). No error.
    - cmd = 000 (NOP): -> IDLE.
    - READ or RESET with valid address: latch CMD/ADDR -> ISSUE.
    - WRITE with valid address: latch CMD/ADDR, clear payload and counter -> DATA.
    - Any other cmd, or an invalid address: ERR_O pulse -> IDLE.
  - DATA: a non-ESC byte is stored at payload[8*cnt +: 8] and cnt increments.
    - ESC -> DATA_ESC.
    - When cnt reaches the payload length for ADDR -> ISSUE.
  - DATA_ESC: the byte after ESC decides.
    - ESC: stored as a literal 8'hB1, counted, -> DATA (or -> ISSUE if this was the last byte).
    - Any other byte: current frame aborted, ERR_O pulse, that byte treated as a new command byte (HEADER rules apply in the same cycle).
  - ISSUE: CMD_VALID_O = 1, with CMD_O/ADDR_O/WDATA_O held stable.
    - On CMD_VALID_O and CMD_READY_I: -> IDLE the next cycle and CMD_VALID_O drops.
- Latency: CMD_VALID_O rises on the clock edge after the final byte (command byte or last payload byte) is accepted.
- WDATA_O holds its last value outside ISSUE. For READ and RESET, WDATA_O is 0.
- Timeout: in HEADER, DATA and DATA_ESC, the timeout counter increments every cycle without an accepted byte and clears on each accepted byte.
  - At TIMEOUT_CYCLES: ERR_O pulse -> IDLE.
  - ISSUE has no timeout.
- ERR_O is exactly one cycle per dropped frame. It never coincides with CMD_VALID_O rising.
- Asynchronous reset mid-frame or mid-ISSUE: immediate return to reset values; a pending command is lost.
- Bits above the address width in WDATA_O (e.g. [47:41] for DMI) are passed through unmodified; the consumer truncates them.

Test Plan:
- Single write: B1, 51, 06 00 00 00 40 FC, with CMD_READY_I tied high -> one CMD_VALID_O pulse with CMD=010, ADDR=11, WDATA=48'hFC4000000006; ERR_O stays 0.
- Read and stall: B1, 30, CMD_READY_I low for 20 cycles -> CMD_VALID_O held for those 20 cycles with CMD=001, ADDR=10; RX_READY_O low throughout; both return to IDLE values one cycle after CMD_READY_I goes high.
- Escaped payload: B1, 30 is not used here; send B1, 50, B1 B1, 01, 02, 03 -> WRITE to DTMCS with WDATA[31:0]=32'h030201B1.
- Resync: B1, 51, 06 00, B1, 31 -> ERR_O pulses once, followed by a READ of DMI (ADDR=11); no WRITE is issued.
- Invalid frames: B1, 4A (WRITE to address 0A), then B1, E0 (cmd 111) -> two separate ERR_O pulses and no CMD_VALID_O; garbage bytes 00 and FF sent while in IDLE produce no ERR_O.
- Timeout and reset: B1, 51, 06 followed by TIMEOUT_CYCLES idle cycles -> ERR_O pulse and return to IDLE; a separate run with RST_NI asserted mid-payload -> all outputs 0 immediately, and the next full frame decodes correctly.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// Frame decoder between the UART receiver and the DTM register/DMI logic.
// Strips ESC framing from the byte stream and issues one command per completed frame.
module uart_cmd_decoder #(
  parameter logic [7:0]  ESC            = 8'hB1,
  parameter int unsigned MAX_BYTES      = 6,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   CLK_I,
  input  logic                   RST_NI,
  input  logic [7:0]             RX_DATA_I,
  input  logic                   RX_VALID_I,
  output logic                   RX_READY_O,
  output logic [2:0]             CMD_O,
  output logic [4:0]             ADDR_O,
  output logic [8*MAX_BYTES-1:0] WDATA_O,
  output logic                   CMD_VALID_O,
  input  logic                   CMD_READY_I,
  output logic                   ERR_O
);

  localparam int unsigned DW = 8 * MAX_BYTES;
  localparam int unsigned CW = $clog2(MAX_BYTES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b010;
  localparam logic [2:0] CMD_RESET = 3'b011;

  localparam logic [4:0] ADDR_DTMCS = 5'h10;
  localparam logic [4:0] ADDR_DMI   = 5'h11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_DATA_ESC,
    S_ISSUE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   payload_q, payload_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [4:0]      addr_q, addr_d;
  logic            valid_q;
  logic            rdy_q;
  logic            err_d;
  logic            err_p_q;
  logic            err_q;

  logic            acc;
  logic            rx_esc;
  logic [2:0]      hdr_cmd;
  logic [4:0]      hdr_addr;
  logic            hdr_en;
  logic            store_en;

  function automatic logic addr_ok(input logic [4:0] a);
    return (a == ADDR_DTMCS) || (a == ADDR_DMI) || (a <= 5'h03);
  endfunction

  function automatic logic [CW-1:0] frame_len(input logic [4:0] a);
    return (a == ADDR_DMI) ? CW'(6) : CW'(4);
  endfunction

  assign acc      = RX_VALID_I && rdy_q;
  assign rx_esc   = (RX_DATA_I == ESC);
  assign hdr_cmd  = RX_DATA_I[7:5];
  assign hdr_addr = RX_DATA_I[4:0];

  // Next-state, payload assembly, timeout and error generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    wdata_d   = wdata_q;
    tmo_d     = tmo_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    err_d     = 1'b0;
    hdr_en    = 1'b0;
    store_en  = 1'b0;

    case (state_q)
      S_IDLE:     if (acc && rx_esc) state_d = S_HEADER;
      S_HEADER:   if (acc && !rx_esc) hdr_en = 1'b1;
      S_DATA: begin
        if (acc) begin
          if (rx_esc) state_d = S_DATA_ESC;
          else        store_en = 1'b1;
        end
      end
      S_DATA_ESC: begin
        if (acc) begin
          if (rx_esc) begin
            store_en = 1'b1;
          end else begin
            err_d  = 1'b1;
            hdr_en = 1'b1;
          end
        end
      end
      S_ISSUE:    if (CMD_READY_I) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Command byte decode, shared by HEADER and the resync path out of DATA_ESC
    if (hdr_en) begin
      state_d = S_IDLE;
      if (hdr_cmd == CMD_NOP) begin
        state_d = S_IDLE;
      end else if (addr_ok(hdr_addr) && (hdr_cmd == CMD_READ || hdr_cmd == CMD_RESET)) begin
        cmd_d   = hdr_cmd;
        addr_d  = hdr_addr;
        state_d = S_ISSUE;
      end else if (addr_ok(hdr_addr) && hdr_cmd == CMD_WRITE) begin
        cmd_d     = hdr_cmd;
        addr_d    = hdr_addr;
        payload_d = '0;
        cnt_d     = '0;
        state_d   = S_DATA;
      end else begin
        err_d = 1'b1;
      end
    end

    if (store_en) begin
      for (int unsigned i = 0; i < MAX_BYTES; i++) begin
        if (cnt_q == CW'(i)) payload_d[8*i +: 8] = RX_DATA_I;
      end
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_d == frame_len(addr_q)) ? S_ISSUE : S_DATA;
    end

    if (state_q == S_HEADER || state_q == S_DATA || state_q == S_DATA_ESC) begin
      if (acc) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_d   = '0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end

    // Output payload is frozen on ISSUE entry so it stays stable while the frame assembles
    if (state_d == S_ISSUE && state_q != S_ISSUE) begin
      wdata_d = (cmd_d == CMD_WRITE) ? payload_d : '0;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      payload_q <= '0;
      wdata_q   <= '0;
      tmo_q     <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      rdy_q     <= 1'b0;
      err_p_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      wdata_q   <= wdata_d;
      tmo_q     <= tmo_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      valid_q   <= (state_d == S_ISSUE);
      rdy_q     <= (state_d != S_ISSUE);
      // Extra stage keeps an abort pulse clear of a command issued from the same byte
      err_p_q   <= err_d;
      err_q     <= err_p_q;
    end
  end

  assign RX_READY_O  = rdy_q;
  assign CMD_O       = cmd_q;
  assign ADDR_O      = addr_q;
  assign WDATA_O     = wdata_q;
  assign CMD_VALID_O = valid_q;
  assign ERR_O       = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: framing, escapes, resync, errors, stall, timeout, reset.
module tb_uart_cmd_decoder;

  localparam int unsigned TMO = 4096;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [2:0]  cmd;
  logic [4:0]  addr;
  logic [47:0] wdata;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  int          vrise = 0;
  int          err_rise = 0;
  int          err_cycles = 0;
  int          coincide = 0;
  logic        v_prev = 1'b0;
  logic        e_prev = 1'b0;
  logic [2:0]  cap_cmd = '0;
  logic [4:0]  cap_addr = '0;
  logic [47:0] cap_wdata = '0;

  uart_cmd_decoder #(.ESC(8'hB1), .MAX_BYTES(6), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK_I       (clk),
    .RST_NI      (rst_n),
    .RX_DATA_I   (rx_data),
    .RX_VALID_I  (rx_valid),
    .RX_READY_O  (rx_ready),
    .CMD_O       (cmd),
    .ADDR_O      (addr),
    .WDATA_O     (wdata),
    .CMD_VALID_O (cmd_valid),
    .CMD_READY_I (cmd_ready),
    .ERR_O       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event monitor sampled on the falling edge
  always @(negedge clk) begin
    v_prev <= cmd_valid;
    e_prev <= err;
    if (err) err_cycles <= err_cycles + 1;
    if (err && !e_prev) err_rise <= err_rise + 1;
    if (cmd_valid && !v_prev) begin
      vrise     <= vrise + 1;
      cap_cmd   <= cmd;
      cap_addr  <= addr;
      cap_wdata <= wdata;
      if (err) coincide <= coincide + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte_ready got rx_ready=%b want 1", rx_ready);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; cmd_ready = 1'b1;
    settle(2);
    n_checks++;
    if ({rx_ready, cmd, addr, wdata, cmd_valid, err} !== 59'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0", {rx_ready, cmd, addr, wdata, cmd_valid, err});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rx_ready !== 1'b1 || cmd_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got rdy=%b vld=%b err=%b want 1 0 0", rx_ready, cmd_valid, err);
    end
  endtask

  task automatic test_single_write;
    int v0, e0;
    logic vnow;
    v0 = vrise; e0 = err_rise;
    send_byte(8'hB1); send_byte(8'h51);
    send_byte(8'h06); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h40); send_byte(8'hFC);
    vnow = cmd_valid;
    settle(4);
    n_checks++;
    if (vnow !== 1'b1) begin n_fail++; $display("FAIL write_latency got vld=%b want 1", vnow); end
    n_checks++;
    if (vrise - v0 != 1) begin n_fail++; $display("FAIL write_count got %0d want 1", vrise - v0); end
    n_checks++;
    if (cap_cmd !== 3'b010 || cap_addr !== 5'h11) begin
      n_fail++; $display("FAIL write_cmd_addr got %b/%h want 010/11", cap_cmd, cap_addr);
    end
    n_checks++;
    if (cap_wdata !== 48'hFC4000000006) begin
      n_fail++; $display("FAIL write_data got %h want fc4000000006", cap_wdata);
    end
    n_checks++;
    if (err_rise - e0 != 0) begin n_fail++; $display("FAIL write_err got %0d want 0", err_rise - e0); end
  endtask

  task automatic test_read_stall;
    int bad;
    cmd_ready = 1'b0;
    send_byte(8'hB1); send_byte(8'h30);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || rx_ready !== 1'b0 || cmd !== 3'b001 || addr !== 5'h10 || wdata !== 48'h0)
        bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL read_stall_hold got %0d bad cycles want 0", bad); end
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (cmd_valid !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL read_release got vld=%b rdy=%b want 0 1", cmd_valid, rx_ready);
    end
  endtask

  task automatic test_escape;
    int v0;
    v0 = vrise;
    send_byte(8'hB1); send_byte(8'h50); send_byte(8'hB1); send_byte(8'hB1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    settle(3);
    n_checks++;
    if (vrise - v0 != 1 || cap_cmd !== 3'b010 || cap_addr !== 5'h10 || cap_wdata !== 48'h0000030201B1) begin
      n_fail++;
      $display("FAIL escape_write got n=%0d %b/%h/%h want 1 010/10/0000030201b1",
               vrise - v0, cap_cmd, cap_addr, cap_wdata);
    end
  endtask

  task automatic test_resync;
    int v0, e0, c0;
    v0 = vrise; e0 = err_rise; c0 = coincide;
    send_byte(8'hB1); send_byte(8'h51); send_byte(8'h06); send_byte(8'h00);
    send_byte(8'hB1); send_byte(8'h31);
    settle(5);
    n_checks++;
    if (err_rise - e0 != 1) begin n_fail++; $display("FAIL resync_err got %0d want 1", err_rise - e0); end
    n_checks++;
    if (vrise - v0 != 1 || cap_cmd !== 3'b001 || cap_addr !== 5'h11) begin
      n_fail++; $display("FAIL resync_read got n=%0d %b/%h want 1 001/11", vrise - v0, cap_cmd, cap_addr);
    end
    n_checks++;
    if (coincide != c0) begin n_fail++; $display("FAIL resync_coincide got %0d want %0d", coincide, c0); end
  endtask

  task automatic test_invalid;
    int v0, e0, ec0;
    v0 = vrise; e0 = err_rise; ec0 = err_cycles;
    send_byte(8'hB1); send_byte(8'h4A);
    send_byte(8'hB1); send_byte(8'hE0);
    settle(5);
    n_checks++;
    if (err_rise - e0 != 2) begin n_fail++; $display("FAIL invalid_err got %0d want 2", err_rise - e0); end
    n_checks++;
    if (err_cycles - ec0 != 2) begin n_fail++; $display("FAIL invalid_width got %0d want 2", err_cycles - ec0); end
    n_checks++;
    if (vrise != v0) begin n_fail++; $display("FAIL invalid_cmd got %0d want 0", vrise - v0); end
    e0 = err_rise;
    send_byte(8'h00); send_byte(8'hFF);
    settle(5);
    n_checks++;
    if (err_rise != e0 || vrise != v0) begin
      n_fail++; $display("FAIL idle_garbage got err=%0d cmd=%0d want 0 0", err_rise - e0, vrise - v0);
    end
  endtask

  task automatic test_timeout;
    int n, v0;
    v0 = vrise;
    send_byte(8'hB1); send_byte(8'h51); send_byte(8'h06);
    n = 0;
    while (!err && n < TMO + 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n < TMO || n > TMO + 4) begin
      n_fail++; $display("FAIL timeout_delay got %0d cycles want %0d..%0d", n, TMO, TMO + 4);
    end
    settle(3);
    n_checks++;
    if (vrise != v0 || rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL timeout_idle got cmds=%0d rdy=%b want 0 1", vrise - v0, rx_ready);
    end
    send_byte(8'hB1); send_byte(8'h31);
    settle(3);
    n_checks++;
    if (vrise - v0 != 1 || cap_cmd !== 3'b001 || cap_addr !== 5'h11) begin
      n_fail++; $display("FAIL timeout_recover got n=%0d %b/%h want 1 001/11", vrise - v0, cap_cmd, cap_addr);
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    send_byte(8'hB1); send_byte(8'h51); send_byte(8'h06); send_byte(8'h00);
    @(negedge clk) rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rx_ready, cmd, addr, wdata, cmd_valid, err} !== 59'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs got %h want 0", {rx_ready, cmd, addr, wdata, cmd_valid, err});
    end
    @(negedge clk) rst_n = 1'b1;
    settle(2);
    v0 = vrise;
    send_byte(8'hB1); send_byte(8'h42);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    settle(3);
    n_checks++;
    if (vrise - v0 != 1 || cap_cmd !== 3'b010 || cap_addr !== 5'h02 || cap_wdata !== 48'h000044332211) begin
      n_fail++;
      $display("FAIL midreset_recover got n=%0d %b/%h/%h want 1 010/02/000044332211",
               vrise - v0, cap_cmd, cap_addr, cap_wdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_stall();
    test_escape();
    test_resync();
    test_invalid();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
